chan_sequencer: RTL and testbench
=================================

// Module: chan_sequencer
// PURPOSE: Channel-side sequencer for the parallel bus-and-tag interface; runs one complete CCW per start.
//   Phases: initial selection, command out, initial status, byte-by-byte WRITE/READ data, stop, ending status.
//   Sits between the host command block and the channel "B" pins; the mock control unit answers on the far side.
// PARAMETERS:
//   TIMEOUT  16'd1000  cycles one wait state may last before abort (only with CHAN_WATCHDOG_EN)
//   CMD_WRITE 8'h01 / CMD_READ 8'h02  command codes that enter the data phase; all others skip it
// PORTS:
//   clk             in   1   single clock, all logic on posedge
//   reset           in   1   synchronous, active-high
//   start           in   1   one-cycle request; sampled only when busy=0
//   dev_addr        in   8   device address for selection
//   cmd             in   8   command byte
//   limit           in   16  byte count for data phase
//   busy            out  1   sequence in progress
//   done            out  1   one-cycle pulse at end of every sequence (ok or error)
//   err             out  2   0 ok, 1 no device (select_in returned), 2 address mismatch, 3 timeout
//   status          out  8   last status byte accepted (initial, then ending)
//   count           out  16  bytes transferred in current/last sequence
//   tx_data         in   8   WRITE data
//   tx_valid        in   1   tx_data valid
//   tx_ready        out  1   pulse: tx_data consumed this cycle
//   rx_data         out  8   READ data
//   rx_valid        out  1   pulse: rx_data valid
//   bus_out         out  8   channel bus out
//   operational_out, hold_out, select_out, address_out, command_out, service_out  out 1 each  outbound tags
//   bus_in          in   8   channel bus in
//   operational_in, select_in, address_in, status_in, service_in  in 1 each  inbound tags
// BEHAVIOUR:
//   Reset: every output 0, state IDLE, count 0; operational_out rises the first cycle after reset falls and stays 1.
//   Reset mid-sequence drops all tags next edge; no done pulse. All outputs registered; 1-cycle tag response.
//   IDLE: start&!busy -> latch dev_addr/cmd/limit, count<=0, bus_out<=dev_addr, address_out=1, hold_out=select_out=1 -> SEL.
//   SEL: operational_in -> address_out=0 -> ADDR; select_in (selection propagated out) -> err=1 -> END.
//   ADDR: address_in -> bus_in!=dev_addr: err=2 -> END; else bus_out<=cmd, command_out=1 -> CMD.
//   CMD: !address_in -> command_out=0 -> ISTAT.
//   ISTAT: status_in -> status<=bus_in, service_out=1; !status_in -> service_out=0; then:
//     status[3] (busy) or status[5]&status[4] (CE+DE) -> END ok.
//     cmd==CMD_WRITE/CMD_READ -> DATA; else -> FSTAT.
//   DATA, on service_in:
//     count==limit -> command_out=1 (stop), wait !service_in, command_out=0 -> FSTAT.
//     WRITE: wait tx_valid, bus_out<=tx_data, tx_ready pulse, service_out=1.
//     READ: rx_data<=bus_in, rx_valid pulse, service_out=1.
//     then wait !service_in, service_out=0, count<=count+1 (16-bit, saturates at limit).
//   DATA: status_in with service_in low -> FSTAT (CU-ended short transfer); limit=0 -> first service_in answered with stop.
//   FSTAT: status_in -> status<=bus_in, service_out=1; !status_in -> service_out=0 -> END.
//   END: hold_out=select_out=address_out=command_out=service_out=0, done=1, busy=0 -> IDLE.
//   start while busy ignored; done and a new start in the same cycle: start ignored.
// CONFIGURATION: macro CHAN_WATCHDOG_EN
//   defined: per-state cycle counter cleared on each transition; reaching TIMEOUT in any non-IDLE wait -> err=3 -> END.
//   undefined: waits indefinitely; err=3 never produced; counter logic absent.
// STRUCTURE:
//   chan_pkg: state enum, err codes, status bit indices (CE=5, DE=4, BUSY=3, UC=6), command code constants.
//   Sub-module chan_watchdog (clear, enable, expired) instantiated only under CHAN_WATCHDOG_EN.
// TESTING (bench pairs with mock CU, ADDRESS=8'hff, mock_limit=4):
//   NOP: dev_addr=ff, cmd=03 -> status=30, count=0, err=0, done one pulse, all outbound tags 0 after.
//   WRITE, limit=4, tx bytes a0..a3 -> CU logs a0..a3, four tx_ready pulses, count=4, ending status=30.
//   READ, limit=2 -> rx_data 01,02; stop via command_out on 3rd service_in; count=2, status=30.
//   mock_busy=1, cmd=01 -> status=08, no data phase, err=0, count=0.
//   dev_addr=12 (no device) -> select_in returns -> err=1, done; with CHAN_WATCHDOG_EN, CU held idle -> err=3 after TIMEOUT cycles.
//   reset asserted in DATA after 2 bytes -> next edge all outputs 0, busy=0, no done; new start completes normally.

Source files
------------

// File: rtl/chan_pkg.sv
// Purpose : shared types and constants for the channel sequencer slice.
//           State encoding, error codes, status-byte bit positions, command
//           codes, watchdog limit and the registered-output bundle.
// Options : CHAN_WATCHDOG_EN (see chan_sequencer.sv) uses WD_TIMEOUT.
package chan_pkg;

    localparam logic [7:0]  CMD_WRITE  = 8'h01;
    localparam logic [7:0]  CMD_READ   = 8'h02;
    localparam logic [15:0] WD_TIMEOUT = 16'd1000;

    // Status byte bit positions
    localparam int ST_UC   = 6;
    localparam int ST_CE   = 5;
    localparam int ST_DE   = 4;
    localparam int ST_BUSY = 3;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NODEV   = 2'd1,
        ERR_ADDR    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL,
        S_ADDR,
        S_CMD,
        S_ISTAT,
        S_ISTAT_ACK,
        S_DATA,
        S_DATA_TX,
        S_DATA_ACK,
        S_DATA_STOP,
        S_FSTAT,
        S_FSTAT_ACK,
        S_END
    } state_e;

    // Every output of the sequencer lives in one register of this type.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic [1:0]  err;
        logic [7:0]  status;
        logic [15:0] count;
        logic        tx_ready;
        logic [7:0]  rx_data;
        logic        rx_valid;
        logic [7:0]  bus_out;
        logic        hold;
        logic        select;
        logic        address;
        logic        command;
        logic        service;
    } chan_out_t;

    // Busy, or channel-end plus device-end, closes the CCW at initial status.
    function automatic logic status_ends(input logic [7:0] st);
        return st[ST_BUSY] | (st[ST_CE] & st[ST_DE]);
    endfunction

    function automatic logic is_data_cmd(input logic [7:0] c);
        return (c == CMD_WRITE) || (c == CMD_READ);
    endfunction

endpackage

// File: rtl/chan_sequencer_if.sv
// Purpose : channel "B" pins between the sequencer and a control unit.
// Signals : bus_out + outbound tags (operational/hold/select/address/
//           command/service) driven by the channel; bus_in + inbound tags
//           (operational/select/address/status/service) driven by the CU.
// Modports: master = channel side, slave = control-unit side.
interface chan_sequencer_if;
    logic [7:0] bus_out;
    logic       operational_out;
    logic       hold_out;
    logic       select_out;
    logic       address_out;
    logic       command_out;
    logic       service_out;

    logic [7:0] bus_in;
    logic       operational_in;
    logic       select_in;
    logic       address_in;
    logic       status_in;
    logic       service_in;

    modport master (
        output bus_out, operational_out, hold_out, select_out,
               address_out, command_out, service_out,
        input  bus_in, operational_in, select_in, address_in,
               status_in, service_in
    );

    modport slave (
        input  bus_out, operational_out, hold_out, select_out,
               address_out, command_out, service_out,
        output bus_in, operational_in, select_in, address_in,
               status_in, service_in
    );
endinterface

// File: rtl/chan_watchdog.sv
// Purpose : per-state wait counter; flags a wait that has lasted TIMEOUT
//           cycles. Only instantiated when CHAN_WATCHDOG_EN is defined.
// Ports   : clk, reset (sync, high); clear restarts the count (state
//           change); enable counts while in a wait state; expired is high on
//           the TIMEOUT-th cycle of one state.
module chan_watchdog
    import chan_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = WD_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [15:0] LAST = TIMEOUT - 16'd1;

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear || !enable)
            cnt <= '0;
        else if (cnt != 16'hffff)
            cnt <= cnt + 16'd1;
    end

    // Independent of clear: clear is derived from the next state, which
    // itself depends on expired.
    assign expired = enable && (cnt >= LAST);
endmodule

// File: rtl/chan_sequencer.sv
// Purpose : channel-side sequencer; runs one complete CCW per start:
//           selection, command out, initial status, byte-wise WRITE/READ
//           data, stop, ending status.
// Ports   : clk, reset (sync, high)
//           host : start, dev_addr, cmd, limit -> busy, done, err, status,
//                  count
//           data : tx_data/tx_valid -> tx_ready (pulse); rx_data/rx_valid
//           ch   : chan_sequencer_if.master, channel bus and tags
// Options : CHAN_WATCHDOG_EN adds chan_watchdog; a wait state lasting
//           WD_TIMEOUT cycles aborts with err=3. Without it waits are
//           unbounded and err=3 never occurs.
module chan_sequencer
    import chan_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         dev_addr,
    input  logic [7:0]         cmd,
    input  logic [15:0]        limit,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err,
    output logic [7:0]         status,
    output logic [15:0]        count,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    chan_sequencer_if.master   ch
);

    state_e    state, state_nxt;
    chan_out_t q, d;
    logic      op_q;
    logic [7:0]  addr_q, cmd_q;
    logic [15:0] limit_q;
    logic      wd_expired;

`ifdef CHAN_WATCHDOG_EN
    chan_watchdog #(.TIMEOUT(WD_TIMEOUT)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_nxt != state),
        .enable  (state != S_IDLE && state != S_END),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_SEL;
            S_SEL:       if (ch.operational_in) state_nxt = S_ADDR;
                         else if (ch.select_in)  state_nxt = S_END;
            S_ADDR:      if (ch.address_in)
                             state_nxt = (ch.bus_in != addr_q) ? S_END : S_CMD;
            S_CMD:       if (!ch.address_in) state_nxt = S_ISTAT;
            S_ISTAT:     if (ch.status_in) state_nxt = S_ISTAT_ACK;
            S_ISTAT_ACK: if (!ch.status_in) begin
                             if (status_ends(q.status))  state_nxt = S_END;
                             else if (is_data_cmd(cmd_q)) state_nxt = S_DATA;
                             else                         state_nxt = S_FSTAT;
                         end
            S_DATA:      if (ch.service_in) begin
                             if (q.count == limit_q)                   state_nxt = S_DATA_STOP;
                             else if (cmd_q == CMD_READ || tx_valid)  state_nxt = S_DATA_ACK;
                             else                                     state_nxt = S_DATA_TX;
                         end else if (ch.status_in) begin
                             // CU ended the transfer short
                             state_nxt = S_FSTAT;
                         end
            S_DATA_TX:   if (tx_valid) state_nxt = S_DATA_ACK;
            S_DATA_ACK:  if (!ch.service_in) state_nxt = S_DATA;
            S_DATA_STOP: if (!ch.service_in) state_nxt = S_FSTAT;
            S_FSTAT:     if (ch.status_in) state_nxt = S_FSTAT_ACK;
            S_FSTAT_ACK: if (!ch.status_in) state_nxt = S_END;
            S_END:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (wd_expired) state_nxt = S_END;
    end

    // Next value of every registered output
    always_comb begin
        d          = q;
        d.done     = 1'b0;
        d.tx_ready = 1'b0;
        d.rx_valid = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                d.busy    = 1'b1;
                d.err     = ERR_OK;
                d.status  = '0;
                d.count   = '0;
                d.bus_out = dev_addr;
                d.address = 1'b1;
                d.hold    = 1'b1;
                d.select  = 1'b1;
            end
            S_SEL: begin
                if (ch.operational_in)  d.address = 1'b0;
                else if (ch.select_in)  d.err     = ERR_NODEV;
            end
            S_ADDR: if (ch.address_in) begin
                if (ch.bus_in != addr_q) begin
                    d.err = ERR_ADDR;
                end else begin
                    d.bus_out = cmd_q;
                    d.command = 1'b1;
                end
            end
            S_CMD: if (!ch.address_in) d.command = 1'b0;
            S_ISTAT, S_FSTAT: if (ch.status_in) begin
                d.status  = ch.bus_in;
                d.service = 1'b1;
            end
            S_ISTAT_ACK, S_FSTAT_ACK: if (!ch.status_in) d.service = 1'b0;
            S_DATA: if (ch.service_in) begin
                if (q.count == limit_q) begin
                    d.command = 1'b1;   // stop
                end else if (cmd_q == CMD_READ) begin
                    d.rx_data  = ch.bus_in;
                    d.rx_valid = 1'b1;
                    d.service  = 1'b1;
                end else if (tx_valid) begin
                    d.bus_out  = tx_data;
                    d.tx_ready = 1'b1;
                    d.service  = 1'b1;
                end
            end
            S_DATA_TX: if (tx_valid) begin
                d.bus_out  = tx_data;
                d.tx_ready = 1'b1;
                d.service  = 1'b1;
            end
            S_DATA_ACK: if (!ch.service_in) begin
                d.service = 1'b0;
                if (q.count != limit_q) d.count = q.count + 16'd1;
            end
            S_DATA_STOP: if (!ch.service_in) d.command = 1'b0;
            default: ;
        endcase
        if (wd_expired) d.err = ERR_TIMEOUT;
        // Entering END always releases the interface and signals completion.
        if (state_nxt == S_END) begin
            d.hold    = 1'b0;
            d.select  = 1'b0;
            d.address = 1'b0;
            d.command = 1'b0;
            d.service = 1'b0;
            d.busy    = 1'b0;
            d.done    = 1'b1;
        end
    end

    // Output and request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= '0;
            limit_q <= '0;
        end else begin
            q    <= d;
            op_q <= 1'b1;
            if (state == S_IDLE && start) begin
                addr_q  <= dev_addr;
                cmd_q   <= cmd;
                limit_q <= limit;
            end
        end
    end

    assign busy     = q.busy;
    assign done     = q.done;
    assign err      = q.err;
    assign status   = q.status;
    assign count    = q.count;
    assign tx_ready = q.tx_ready;
    assign rx_data  = q.rx_data;
    assign rx_valid = q.rx_valid;

    assign ch.bus_out         = q.bus_out;
    assign ch.operational_out = op_q;
    assign ch.hold_out        = q.hold;
    assign ch.select_out      = q.select;
    assign ch.address_out     = q.address;
    assign ch.command_out     = q.command;
    assign ch.service_out     = q.service;
endmodule

// File: tb/tb_chan_sequencer.sv
// Bench for chan_sequencer with a behavioural mock control unit
// (address 8'hff, offers at most 4 data bytes). Expected completions,
// rx bytes and tx bytes are queued when a sequence is launched and
// popped by monitors as the DUT produces them.
`timescale 1ns/1ps
module tb_chan_sequencer;
    import chan_pkg::*;

    localparam logic [7:0] ADDRESS    = 8'hff;
    localparam int         MOCK_LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [7:0]  dev_addr = '0, cmd = '0;
    logic [15:0] limit = '0;
    logic        busy, done;
    logic [1:0]  err;
    logic [7:0]  status;
    logic [15:0] count;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    chan_sequencer_if ch();

    chan_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .dev_addr(dev_addr),
        .cmd(cmd), .limit(limit), .busy(busy), .done(done), .err(err),
        .status(status), .count(count), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .ch(ch)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, err, status, count, tx_ready, rx_data, rx_valid,
                    ch.bus_out, ch.operational_out, ch.hold_out, ch.select_out,
                    ch.address_out, ch.command_out, ch.service_out});
    endfunction

    typedef struct {
        logic [1:0]  err;
        logic [7:0]  status;
        logic [15:0] count;
    } res_t;

    res_t       done_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] cu_log[$];
    int         done_n = 0;
    int         txr_n  = 0;

    bit mock_busy = 0, mock_mute = 0, mock_bad_addr = 0;

    // ---------------- mock control unit ----------------
    typedef enum int {M_IDLE, M_SELP, M_OPL, M_ADDR, M_CMD, M_IST, M_ISTD,
                      M_DW, M_DS, M_DA, M_STOP, M_FST, M_WAIT} mst_e;
    mst_e       ms;
    int         mcount;
    logic [7:0] mcmd;

    always @(posedge clk) begin
        if (reset || (ms != M_IDLE && !ch.hold_out)) begin
            ms <= M_IDLE;
            mcount <= 0;
            mcmd <= '0;
            ch.bus_in <= '0;
            ch.operational_in <= 1'b0;
            ch.select_in <= 1'b0;
            ch.address_in <= 1'b0;
            ch.status_in <= 1'b0;
            ch.service_in <= 1'b0;
        end else if (!mock_mute) begin
            case (ms)
                M_IDLE: if (ch.select_out && ch.address_out) begin
                    if (ch.bus_out == ADDRESS) begin
                        ch.operational_in <= 1'b1;
                        ms <= M_OPL;
                    end else begin
                        ch.select_in <= 1'b1;
                        ms <= M_SELP;
                    end
                end
                M_OPL: if (!ch.address_out) begin
                    ch.address_in <= 1'b1;
                    ch.bus_in <= mock_bad_addr ? (ADDRESS ^ 8'h0f) : ADDRESS;
                    ms <= M_ADDR;
                end
                M_ADDR: if (ch.command_out) begin
                    mcmd <= ch.bus_out;
                    ch.address_in <= 1'b0;
                    ms <= M_CMD;
                end
                M_CMD: if (!ch.command_out) begin
                    ch.status_in <= 1'b1;
                    ch.bus_in <= mock_busy ? 8'h08 :
                                 (mcmd == CMD_WRITE || mcmd == CMD_READ) ? 8'h00 : 8'h30;
                    ms <= M_IST;
                end
                M_IST: if (ch.service_out) begin
                    ch.status_in <= 1'b0;
                    ms <= M_ISTD;
                end
                M_ISTD: if (!ch.service_out) ms <= (ch.bus_in == 8'h00) ? M_DW : M_WAIT;
                M_DW: begin
                    if (mcount == MOCK_LIMIT) begin
                        ch.status_in <= 1'b1;
                        ch.bus_in <= 8'h30;
                        ms <= M_FST;
                    end else begin
                        ch.service_in <= 1'b1;
                        ch.bus_in <= 8'(mcount + 1);
                        ms <= M_DS;
                    end
                end
                M_DS: begin
                    if (ch.command_out) begin
                        ch.service_in <= 1'b0;
                        ms <= M_STOP;
                    end else if (ch.service_out) begin
                        if (mcmd == CMD_WRITE) cu_log.push_back(ch.bus_out);
                        ch.service_in <= 1'b0;
                        mcount <= mcount + 1;
                        ms <= M_DA;
                    end
                end
                M_DA: if (!ch.service_out) ms <= M_DW;
                M_STOP: if (!ch.command_out) begin
                    ch.status_in <= 1'b1;
                    ch.bus_in <= 8'h30;
                    ms <= M_FST;
                end
                M_FST: if (ch.service_out) begin
                    ch.status_in <= 1'b0;
                    ms <= M_WAIT;
                end
                default: ;
            endcase
        end
    end

    // ---------------- tx source ----------------
    initial forever begin
        @(negedge clk);
        if (tx_ready && tx_bytes.size() > 0) void'(tx_bytes.pop_front());
        tx_valid = (tx_bytes.size() > 0);
        tx_data  = tx_valid ? tx_bytes[0] : 8'h00;
    end

    // ---------------- monitors ----------------
    initial forever begin
        res_t       e;
        logic [7:0] b;
        @(negedge clk);
        if (!reset) begin
            if (done) begin
                done_n++;
                if (done_q.size() == 0) begin
                    chk("done_unexp", 1, 0);
                end else begin
                    e = done_q.pop_front();
                    chk("err", err, e.err);
                    chk("status", status, e.status);
                    chk("count", count, e.count);
                    chk("tags_end", {ch.hold_out, ch.select_out, ch.address_out,
                                     ch.command_out, ch.service_out, busy}, 0);
                end
            end
            if (rx_valid) begin
                if (rx_q.size() == 0) chk("rx_unexp", 1, 0);
                else begin
                    b = rx_q.pop_front();
                    chk("rx_data", rx_data, b);
                end
            end
            if (tx_ready) begin
                txr_n++;
                if (tx_q.size() == 0) chk("tx_unexp", 1, 0);
                else begin
                    b = tx_q.pop_front();
                    chk("tx_bus", ch.bus_out, b);
                end
            end
        end
    end

    // mode 0: plain, 1: start during done cycle, 2: start while busy
    task automatic run_seq(input logic [7:0] a, input logic [7:0] c, input logic [15:0] l,
                           input logic [1:0] e_err, input logic [7:0] e_st,
                           input logic [15:0] e_cnt, input int budget, input int mode);
        res_t r;
        bit   seen;
        r.err = e_err; r.status = e_st; r.count = e_cnt;
        done_q.push_back(r);
        seen = 0;
        @(negedge clk);
        start = 1'b1; dev_addr = a; cmd = c; limit = l;
        @(negedge clk);
        start = 1'b0;
        if (mode == 2) begin
            repeat (4) @(negedge clk);
            start = 1'b1; dev_addr = 8'h12; cmd = 8'h03;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        if (!seen) begin
            chk("seq_timeout", 0, 1);
            done_q.delete();
        end else if (mode == 1) begin
            start = 1'b1; dev_addr = ADDRESS; cmd = 8'h03;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("start_in_done", {busy, ch.select_out, ch.hold_out}, 0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0, txr0;
        bit got2;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", outs(), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("op_out", ch.operational_out, 1);

        // NOP; start in the done cycle is dropped
        run_seq(ADDRESS, 8'h03, 16'd0, ERR_OK, 8'h30, 16'd0, 200, 1);

        // WRITE four bytes
        cu_log.delete();
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(8'ha0 + 8'(i));
            tx_bytes.push_back(8'ha0 + 8'(i));
        end
        txr0 = txr_n;
        run_seq(ADDRESS, CMD_WRITE, 16'd4, ERR_OK, 8'h30, 16'd4, 500, 0);
        chk("tx_ready_n", txr_n - txr0, 4);
        chk("cu_log_n", cu_log.size(), 4);
        for (int i = 0; i < 4 && i < cu_log.size(); i++)
            chk("cu_log", cu_log[i], 8'ha0 + 8'(i));

        // READ two bytes, stopped by the channel; extra start while busy
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h02);
        run_seq(ADDRESS, CMD_READ, 16'd2, ERR_OK, 8'h30, 16'd2, 500, 2);
        chk("rx_left", rx_q.size(), 0);

        // CU busy at initial status
        mock_busy = 1;
        run_seq(ADDRESS, CMD_WRITE, 16'd4, ERR_OK, 8'h08, 16'd0, 300, 0);
        mock_busy = 0;

        // no device
        run_seq(8'h12, 8'h03, 16'd0, ERR_NODEV, 8'h00, 16'd0, 200, 0);

        // address mismatch
        mock_bad_addr = 1;
        run_seq(ADDRESS, 8'h03, 16'd0, ERR_ADDR, 8'h00, 16'd0, 200, 0);
        mock_bad_addr = 0;

`ifdef CHAN_WATCHDOG_EN
        // silent CU
        mock_mute = 1;
        run_seq(ADDRESS, 8'h03, 16'd0, ERR_TIMEOUT, 8'h00, 16'd0, 3000, 0);
        mock_mute = 0;
`endif

        // reset in the data phase after two bytes
        d0 = done_n;
        for (int i = 1; i <= 4; i++) rx_q.push_back(8'(i));
        @(negedge clk);
        start = 1'b1; dev_addr = ADDRESS; cmd = CMD_READ; limit = 16'd4;
        @(negedge clk);
        start = 1'b0;
        got2 = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rx_q.size() <= 2) begin got2 = 1; break; end
        end
        chk("rst_reach_data", got2, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", outs(), 0);
        rx_q.delete();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_done", done_n - d0, 0);
        chk("rst_idle", {busy, ch.hold_out, ch.operational_out}, 3'b001);

        // sequence after reset
        run_seq(ADDRESS, 8'h03, 16'd0, ERR_OK, 8'h30, 16'd0, 200, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end
endmodule
